// File: rtl/data_memory_master.sv
// Load/store access controller for a single-port, word-addressed data memory.
// It accepts one request at a time. Sub-word stores are done as read-modify-write.
//
// state | meaning
// IDLE  | ready for a request; memory outputs parked at zero
// READ  | memory word addressed; read_data captured at end of cycle
// WRITE | write_en asserted with the final word
// RESP  | response presented until resp_ready
module data_memory_master #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] data_address,
  output logic              write_en,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              state_q, state_d;
  logic                wr_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                req_err;
  logic                unused_addr_bits;

  // Address bits above the memory range are ignored.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] lo);
    logic [31:0] sh;
    logic [31:0] res;
    res = word;
    if (size == SZ_BYTE) begin
      sh  = word >> {lo, 3'b000};
      res = {{24{sgn & sh[7]}}, sh[7:0]};
    end else if (size == SZ_HALF) begin
      sh  = word >> {lo[1], 4'b0000};
      res = {{16{sgn & sh[15]}}, sh[15:0]};
    end
    return res;
  endfunction

  // Replace the addressed lane of a memory word with the store data.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] mask;
    logic [31:0] res;
    res = wd;
    if (size == SZ_BYTE) begin
      mask = 32'h0000_00FF << {lo, 3'b000};
      res  = (word & ~mask) | ({24'b0, wd[7:0]} << {lo, 3'b000});
    end else if (size == SZ_HALF) begin
      mask = 32'h0000_FFFF << {lo[1], 4'b0000};
      res  = (word & ~mask) | ({16'b0, wd[15:0]} << {lo[1], 4'b0000});
    end
    return res;
  endfunction

  // Misaligned or illegal-size requests are flagged at accept time.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                           req_err = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])     req_err = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
  end

  // State register and request/response datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          size_q  <= req_size;
          sgn_q   <= req_signed;
          addr_q  <= req_addr[ADDR_W+1:0];
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= req_err;
        end
        READ: begin
          // A sub-word store folds the merged word back into wdata_q for WRITE.
          if (wr_q) wdata_q <= merge(read_data, wdata_q, size_q, addr_q[1:0]);
          else      rdata_q <= extract(read_data, size_q, sgn_q, addr_q[1:0]);
        end
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_err)                          state_d = RESP;
        else if (req_write && req_size == SZ_WORD) state_d = WRITE;
        else                                  state_d = READ;
      end
      READ:  state_d = wr_q ? WRITE : RESP;
      WRITE: state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; reset gating keeps them low while reset is held.
  always_comb begin
    req_ready    = (state_q == IDLE) && !reset;
    write_en     = (state_q == WRITE) && !reset;
    data_address = (state_q != IDLE) ? addr_q[ADDR_W+1:2] : '0;
    write_data   = (state_q != IDLE) ? wdata_q : '0;
    resp_valid   = (state_q == RESP);
    resp_rdata   = (state_q == RESP) ? rdata_q : '0;
    resp_err     = (state_q == RESP) ? err_q : 1'b0;
  end

endmodule

// File: tb/tb_data_memory_master.sv
// Directed bench for data_memory_master with a behavioural memory (ram[i] = i).
module tb_data_memory_master;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] data_address;
  logic              write_en;
  logic [31:0]       write_data;
  logic [31:0]       read_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic        mem_init_done = 1'b0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  data_memory_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .data_address(data_address),
    .write_en(write_en), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign read_data = ram[data_address];

  // Memory model: preload on the first edge, then capture writes and log them.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 32'(i);
      mem_init_done <= 1'b1;
    end else if (write_en) begin
      ram[data_address] <= write_data;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= 32'(data_address);
      wr_data <= write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer a request, wait for accept, then count cycles until resp_valid.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] first_addr);
    int n;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    first_addr = 32'(data_address);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] fa;
  int          wc0;

  initial begin
    // Reset held: everything low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Word load at 0x10.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, fa);
    chk("wl_addr", fa, 32'd4);
    chk("wl_lat", 32'(lat), 32'd2);
    chk("wl_rdata", resp_rdata, 32'h4);
    chk("wl_err", 32'(resp_err), 32'd0);
    finish_resp();

    // Word store 0xDEADBEEF at 0x20.
    wc0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, lat, fa);
    chk("ws_lat", 32'(lat), 32'd2);
    chk("ws_wcnt", 32'(wr_cnt - wc0), 32'd1);
    chk("ws_waddr", wr_addr, 32'd8);
    chk("ws_wdata", wr_data, 32'hDEADBEEF);
    chk("ws_rdata", resp_rdata, 32'h0);
    finish_resp();
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, fa);
    chk("ws_readback", resp_rdata, 32'hDEADBEEF);
    finish_resp();

    // Byte store 0xA5 at 0x21 (read-modify-write).
    wc0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56A5, lat, fa);
    chk("bs_lat", 32'(lat), 32'd3);
    chk("bs_wcnt", 32'(wr_cnt - wc0), 32'd1);
    chk("bs_wdata", wr_data, 32'hDEADA5EF);
    finish_resp();

    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, fa);
    chk("lb_signed", resp_rdata, 32'hFFFFFFA5);
    finish_resp();
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, fa);
    chk("lbu", resp_rdata, 32'h000000A5);
    finish_resp();
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, fa);
    chk("lh_signed", resp_rdata, 32'hFFFFDEAD);
    finish_resp();
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, lat, fa);
    chk("lhu_lo", resp_rdata, 32'h0000A5EF);
    finish_resp();

    // Byte store in the top lane of word 16, then loads of that word.
    issue(1'b1, 2'b00, 1'b0, 32'h43, 32'hFFFF_FF7E, lat, fa);
    chk("bs3_wdata", wr_data, 32'h7E000010);
    finish_resp();
    issue(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, lat, fa);
    chk("lb3_pos", resp_rdata, 32'h0000007E);
    finish_resp();
    issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, lat, fa);
    chk("lhu_hi", resp_rdata, 32'h00007E00);
    finish_resp();

    // Half store 0x1234 at 0x22 on word 8.
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_1234, lat, fa);
    chk("hs_wdata", wr_data, 32'h1234A5EF);
    finish_resp();

    // Error requests: misaligned word load, misaligned half store, illegal size.
    wc0 = wr_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, fa);
    chk("e1_lat", 32'(lat), 32'd1);
    chk("e1_err", 32'(resp_err), 32'd1);
    chk("e1_rdata", resp_rdata, 32'h0);
    finish_resp();
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, lat, fa);
    chk("e2_lat", 32'(lat), 32'd1);
    chk("e2_err", 32'(resp_err), 32'd1);
    chk("e2_rdata", resp_rdata, 32'h0);
    finish_resp();
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, fa);
    chk("e3_lat", 32'(lat), 32'd1);
    chk("e3_err", 32'(resp_err), 32'd1);
    chk("e3_rdata", resp_rdata, 32'h0);
    finish_resp();
    chk("err_no_write", 32'(wr_cnt - wc0), 32'd0);

    // Backpressure with a second request waiting.
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, fa);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h18;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'h5);
      chk("bp_err", 32'(resp_err), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    finish_resp();
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(resp_valid), 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, lat, fa);
    chk("bp_second_lat", 32'(lat), 32'd2);
    chk("bp_second", resp_rdata, 32'h6);
    finish_resp();

    // Reset during the WRITE of a byte store to word 12.
    wc0 = wr_cnt;
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h31;
    req_wdata = 32'h0000_0055; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_read_addr", 32'(data_address), 32'd12);
    @(posedge clk); #1;
    chk("rw_we_before", 32'(write_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_we_dropped", 32'(write_en), 32'd0);
    chk("rw_ready_low", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rw_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rw_post_ready", 32'(req_ready), 32'd1);
    chk("rw_no_resp2", 32'(resp_valid), 32'd0);
    chk("rw_no_write", 32'(wr_cnt - wc0), 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, fa);
    chk("rw_readback", resp_rdata, 32'h0000000C);
    finish_resp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_master.md
# data_memory_master

Load/store access controller that drives the single-port word-addressed data memory on behalf of the CPU datapath. It accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. It translates byte addresses to word addresses and performs sub-word stores as read-modify-write, because the memory only writes whole words. It returns zero- or sign-extended load data, or an error flag for misaligned or illegal requests.

## Interface
- ADDR_W, 15, memory word-address width; memory word address = req_addr[ADDR_W+1:2]

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  controller idle and able to accept
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads only: sign-extend sub-word result
- req_addr  in  32  byte address; bits above ADDR_W+1 ignored
- req_wdata  in  32  store data; sub-word data in low bits
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size
- data_address  out  ADDR_W  memory word address
- write_en  out  1  memory write strobe; memory captures on rising clk
- write_data  out  32  memory write word
- read_data  in  32  memory combinational read data for data_address

## Operation
- States: IDLE, READ, WRITE, RESP.
- Only IDLE asserts req_ready. A request is accepted on a clock edge with req_valid && req_ready. On acceptance the controller latches op, size, signed, address and wdata.
- Error check at accept:
  - size 11 → error.
  - half with addr[0]≠0 → error.
  - word with addr[1:0]≠0 → error.
  - An erroring request goes IDLE→RESP with resp_err=1 and resp_rdata=0. No memory activity occurs.
- Load: IDLE→READ→RESP.
  - In READ, data_address is driven; read_data is captured at the end of the cycle.
  - Result selection: byte lane k=addr[1:0] is bits [8k+7:8k]; half lane is bits [16·addr[1]+15:16·addr[1]]. Little-endian.
  - Extension: zero-extend if req_signed=0, else sign-extend from the lane MSB. Word loads pass through.
- Word store: IDLE→WRITE→RESP. write_en=1 for exactly the WRITE cycle, with write_data=req_wdata.
- Sub-word store: IDLE→READ→WRITE→RESP.
  - The WRITE word is the captured read word with the addressed lane replaced by req_wdata[7:0] or [15:0]. All other lanes are unchanged.
- RESP: resp_valid=1 with resp_rdata/resp_err stable. On resp_ready the controller returns to IDLE. A new request cannot be accepted in that same cycle.
- write_en is 0 in every state except WRITE. data_address and write_data hold the latched values outside IDLE and are 0 in IDLE.

## Timing
- Reset (asynchronous): state=IDLE immediately. All outputs are 0 while reset is high, including req_ready and write_en. req_ready rises in the first cycle after reset deasserts.
- Latency from the accept edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Backpressure: while resp_ready=0, the controller stays in RESP indefinitely. Outputs are held and req_ready stays 0.
- Reset mid-operation (READ or WRITE):
  - write_en drops combinationally with reset.
  - The in-flight request is discarded. No response and no later memory write occur.
  - A write whose edge coincides with reset assertion is not guaranteed.
- Only one outstanding request; no pipelining.

## Test plan
- Memory preloaded with ram[i]=i. Word load at 0x00000010 → data_address=4 in READ; resp_valid 2 cycles after accept; resp_rdata=0x00000004; resp_err=0.
- Word store of 0xDEADBEEF at 0x20 → write_en high exactly 1 cycle with data_address=8 and write_data=0xDEADBEEF. A following word load at 0x20 returns 0xDEADBEEF.
- Sub-word cases on word 8 (=0xDEADBEEF):
  - byte store 0xA5 at 0x21 → READ then WRITE of 0xDEADA5EF; resp 3 cycles after accept.
  - signed byte load at 0x21 → 0xFFFFFFA5.
  - unsigned byte load at 0x21 → 0x000000A5.
  - signed half load at 0x22 → 0xFFFFDEAD.
- Error cases:
  - word load at 0x13 → resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, no write_en.
  - half store at 0x11 → same error response.
  - size 11 → same error response.
- Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 → resp_valid, resp_rdata and resp_err stay stable; req_ready stays 0; the second request is accepted only after the response handshake.
- Assert reset during WRITE of a byte store → write_en=0 immediately; no resp_valid. After release, reading that word returns its pre-store value, and req_ready=1 in the first post-reset cycle.
